// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
interface nibble_serial_adder_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;

   // Producer/consumer side (drives operands, consumes results)
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   // Adder side
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-word adder that walks one nibble per clock through a single
// 4-bit slice, holding the inter-nibble carry in a register.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | one nibble added per cycle, LSB nibble first
// DONE  | result held on sum/cout with out_valid high until out_ready

// Single 4-bit ripple slice.
module adder4bits (
   output logic       cout,
   output logic [3:0] sum,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin
);
   // Plain 5-bit add of two nibbles plus carry-in
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   nibble_serial_adder_if.slave bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int CW = $clog2((NIBBLES < 2) ? 2 : NIBBLES);
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q;
   logic [W-1:0]  sa_q;
   logic [W-1:0]  sb_q;
   logic [W-1:0]  acc_q;
   logic [W-1:0]  sum_q;
   logic          c_q;
   logic          cout_q;
   logic [CW-1:0] cnt_q;

   logic          cout_n;
   logic [3:0]    sum_n;
   logic [W-1:0]  acc_d;

   adder4bits u_slice (cout_n, sum_n, sa_q[3:0], sb_q[3:0], c_q);

   // New nibble enters at the top; after NIBBLES shifts the LSB nibble
   // has reached bit 0. Written as shift/or so it also holds for W = 4.
   assign acc_d = (acc_q >> 4) | (W'(sum_n) << (W - 4));

   // Sequencing FSM with operand/result shift registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         c_q     <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  sa_q    <= bus.a;
                  sb_q    <= bus.b;
                  c_q     <= bus.cin;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               acc_q <= acc_d;
               sa_q  <= sa_q >> 4;
               sb_q  <= sb_q >> 4;
               c_q   <= cout_n;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  sum_q   <= acc_d;
                  cout_q  <= cout_n;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (NIBBLES = 4).
module tb_nibble_serial_adder;
   localparam int NIB   = 4;
   localparam int NRAND = 2000;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   int   cyc;
   int   acc_cyc;
   int   prev_acc_cyc;
   bit   ov_prev;
   bit   rand_done;
   logic [16:0] exp_q[$];

   nibble_serial_adder_if #(.NIBBLES(NIB)) bus ();

   nibble_serial_adder #(.NIBBLES(NIB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Monitor: push on acceptance, compare on every cycle out_valid is high,
   // pop on output transfer. Inputs only change just after posedge, so the
   // negedge view is what the next rising edge will see.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         ov_prev <= 1'b0;
      end else begin
         if (bus.out_valid) begin
            check("result_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() != 0) begin
               check("result", {bus.cout, bus.sum}, exp_q[0]);
               if (!ov_prev) check("latency", cyc - acc_cyc, NIB);
               if (bus.out_ready) void'(exp_q.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back({1'b0, bus.a} + {1'b0, bus.b} + {16'h0000, bus.cin});
            prev_acc_cyc = acc_cyc;
            acc_cyc      = cyc + 1;
         end
         ov_prev <= bus.out_valid;
      end
   end

   task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                       input bit keep_valid);
      int n;
      bus.a        = ta;
      bus.b        = tb;
      bus.cin      = tc;
      bus.in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.in_ready && n < 200);
      if (n >= 200) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (!keep_valid) bus.in_valid = 1'b0;
   endtask

   task automatic wait_out_valid();
      int n;
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("out_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !bus.in_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, bus.out_valid, 1'b0);
      check({tag, "_sum"},       bus.sum,       16'h0000);
      check({tag, "_cout"},      bus.cout,      1'b0);
      check({tag, "_in_ready"},  bus.in_ready,  1'b1);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0; acc_cyc = 0; prev_acc_cyc = 0;
      rand_done = 1'b0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      bus.out_ready = 1'b0;

      // Power-on reset, then an asynchronous reset pulse during IDLE
      #23;
      check_reset_outputs("rst_por");
      @(negedge clk); #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_reset_outputs("rst_idle");
      @(negedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic add with carry-in
      bus.out_ready = 1'b1;
      send(16'h0001, 16'h0000, 1'b1, 1'b0);
      wait_drain();

      // Full carry ripple
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_drain();
      send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      wait_drain();

      // Backpressure with a rejected in_valid pulse
      @(posedge clk); #1 bus.out_ready = 1'b0;
      send(16'h000F, 16'h000F, 1'b0, 1'b0);
      wait_out_valid();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (i == 1) begin
            bus.a = 16'h7777; bus.b = 16'h1111; bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
         check("bp_out_valid", bus.out_valid, 1'b1);
         check("bp_in_ready",  bus.in_ready,  1'b0);
         check("bp_value",     {bus.cout, bus.sum}, 17'h0001E);
      end
      @(posedge clk); #1 bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      @(posedge clk); #1 bus.out_ready = 1'b0;
      @(negedge clk);
      check("bp_idle_after_release", bus.in_ready, 1'b1);
      check("bp_queue_empty", exp_q.size(), 32'd0);

      // Back-to-back with out_ready high
      bus.out_ready = 1'b1;
      send(16'h1234, 16'h4321, 1'b0, 1'b1);
      send(16'hABCD, 16'h1111, 1'b1, 1'b0);
      check("b2b_spacing", acc_cyc - prev_acc_cyc, NIB + 2);
      wait_drain();

      // Reset mid-RUN after two nibbles; the in-flight result must vanish
      send(16'h5A5A, 16'h0F0F, 1'b1, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_reset_outputs("rst_midrun");
      @(negedge clk); #2 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("midrun_no_output", exp_q.size(), 32'd0);

      // Random sweep with input gaps and output stalls
      @(posedge clk); #1;
      fork
         begin
            for (int i = 0; i < NRAND; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
               send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b1;
         end
      join
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
